sync_interval_timer: RTL and testbench



---
 rtl/sync_timer_pkg.sv | 7 +
 rtl/sync_down_counter.sv | 63 ++++++
 rtl/sync_interval_timer.sv | 108 ++++++++++
 tb/tb_sync_interval_timer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_timer_pkg.sv
// Shared types and constants for the interval timer.
package sync_timer_pkg;
  typedef enum logic {ST_STOPPED = 1'b0, ST_RUNNING = 1'b1} tmr_state_e;
  localparam logic MODE_PERIODIC = 1'b1;
  localparam logic MODE_ONESHOT  = 1'b0;
  localparam int   TIMER_W       = 16;
endpackage

// File: rtl/sync_down_counter.sv
// Bit-sliced loadable down counter; each cell passes a borrow to the next,
// so the borrow out of the top cell is also the all-zero flag.
module sync_cnt_cell (
  input  logic gclk,
  input  logic grst,
  input  logic clr_i,
  input  logic ld_i,
  input  logic en_i,
  input  logic d_i,
  input  logic bin_i,
  output logic q_o,
  output logic bout_o
);
  logic q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr_i)              q_d = 1'b0;
    else if (ld_i)          q_d = d_i;
    else if (en_i && bin_i) q_d = ~q_q;
  end

  always_ff @(posedge gclk or posedge grst)
    if (grst) q_q <= 1'b0;
    else      q_q <= q_d;

  assign q_o    = q_q;
  assign bout_o = bin_i & ~q_q;
endmodule

module sync_down_counter
  import sync_timer_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         gclk,
  input  logic         grst,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         zero_o
);
  logic [W:0] brw;
  assign brw[0] = 1'b1;

  for (genvar i = 0; i < W; i++) begin : g_cell
    sync_cnt_cell u_cell (
      .gclk  (gclk),
      .grst  (grst),
      .clr_i (clr_i),
      .ld_i  (ld_i),
      .en_i  (en_i),
      .d_i   (d_i[i]),
      .bin_i (brw[i]),
      .q_o   (q_o[i]),
      .bout_o(brw[i+1])
    );
  end

  assign zero_o = brw[W];
endmodule

// File: rtl/sync_interval_timer.sv
// Programmable interval timer: reload register, run/stop FSM, TC pulse, IRQ latch.
// Optional input prescaler enabled by defining SYNC_TIMER_PRESCALE_EN.
module sync_interval_timer
  import sync_timer_pkg::*;
#(
  parameter int W                = TIMER_W,
  parameter bit PERIODIC_DEFAULT = 1'b1
) (
  input  logic         MasterClock,
  input  logic         RESET,
  input  logic         TICK,
  input  logic [W-1:0] DIN,
  input  logic         LD_RELOAD,
  input  logic         START,
  input  logic         STOP,
  input  logic         MODE_WR,
  input  logic         ACK,
`ifdef SYNC_TIMER_PRESCALE_EN
  input  logic [7:0]   PRESCALE,
`endif
  output logic [W-1:0] COUNT,
  output logic         TC,
  output logic         IRQ,
  output logic         RUNNING
);
  tmr_state_e  state_q, state_d;
  logic [W-1:0] reload_q, cnt_din;
  logic        mode_q, mode_now, tc_q, irq_q;
  logic        term, cnt_ld, cnt_en, zero, tick_eff;

`ifdef SYNC_TIMER_PRESCALE_EN
  logic [7:0] pre_q, pre_d;

  always_comb begin
    pre_d    = pre_q;
    tick_eff = 1'b0;
    if (STOP || START) pre_d = '0;
    else if (state_q == ST_RUNNING && TICK) begin
      if (pre_q == PRESCALE) begin
        pre_d    = '0;
        tick_eff = 1'b1;
      end else pre_d = pre_q + 8'd1;
    end
  end

  always_ff @(posedge MasterClock or posedge RESET)
    if (RESET) pre_q <= '0;
    else       pre_q <= pre_d;
`else
  assign tick_eff = TICK;
`endif

  // A mode write applies to a terminal count on the same edge.
  assign mode_now = MODE_WR ? DIN[0] : mode_q;

  always_ff @(posedge MasterClock or posedge RESET)
    if (RESET) state_q <= ST_STOPPED;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    term    = 1'b0;
    cnt_ld  = 1'b0;
    cnt_en  = 1'b0;
    cnt_din = reload_q;
    if (STOP) state_d = ST_STOPPED;
    else if (START) begin
      state_d = ST_RUNNING;
      cnt_ld  = 1'b1;
      if (LD_RELOAD) cnt_din = DIN;
    end else if (state_q == ST_RUNNING && tick_eff) begin
      if (zero) begin
        term = 1'b1;
        if (mode_now == MODE_ONESHOT) state_d = ST_STOPPED;
        else                          cnt_ld  = 1'b1;
      end else cnt_en = 1'b1;
    end
  end

  always_comb RUNNING = (state_q == ST_RUNNING);

  always_ff @(posedge MasterClock or posedge RESET)
    if (RESET) begin
      reload_q <= '0;
      mode_q   <= PERIODIC_DEFAULT;
      tc_q     <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (LD_RELOAD) reload_q <= DIN;
      mode_q <= mode_now;
      tc_q   <= term;
      irq_q  <= term | (irq_q & ~ACK);
    end

  sync_down_counter #(.W(W)) u_cnt (
    .gclk  (MasterClock),
    .grst  (RESET),
    .clr_i (1'b0),
    .ld_i  (cnt_ld),
    .en_i  (cnt_en),
    .d_i   (cnt_din),
    .q_o   (COUNT),
    .zero_o(zero)
  );

  assign TC  = tc_q;
  assign IRQ = irq_q;
endmodule

// File: tb/tb_sync_interval_timer.sv
// Scoreboard bench for sync_interval_timer: directed plan items plus random traffic.
module tb_sync_interval_timer;
  localparam int W = 16;

  logic MasterClock = 1'b0;
  logic RESET, TICK, LD_RELOAD, START, STOP, MODE_WR, ACK;
  logic [W-1:0] DIN;
`ifdef SYNC_TIMER_PRESCALE_EN
  logic [7:0] PRESCALE;
  int ps;
`endif
  wire [W-1:0] COUNT;
  wire TC, IRQ, RUNNING;

  sync_interval_timer #(.W(W), .PERIODIC_DEFAULT(1'b1)) dut (
    .MasterClock(MasterClock),
    .RESET      (RESET),
    .TICK       (TICK),
    .DIN        (DIN),
    .LD_RELOAD  (LD_RELOAD),
    .START      (START),
    .STOP       (STOP),
    .MODE_WR    (MODE_WR),
    .ACK        (ACK),
`ifdef SYNC_TIMER_PRESCALE_EN
    .PRESCALE   (PRESCALE),
`endif
    .COUNT      (COUNT),
    .TC         (TC),
    .IRQ        (IRQ),
    .RUNNING    (RUNNING)
  );

  always #5 MasterClock = ~MasterClock;

  typedef struct {int cnt; bit tc; bit irq; bit run;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_bad = 0;
  int m_cnt, m_rel, m_pre;
  bit m_mode, m_run, m_tc, m_irq;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_rel = 0; m_pre = 0;
    m_mode = 1'b1; m_run = 1'b0; m_tc = 1'b0; m_irq = 1'b0;
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state, then compare.
  task automatic step(input bit tk, input bit ld, input bit st, input bit sp,
                      input bit mw, input bit ak, input int d);
    bit te, term;
    exp_t e;
    TICK = tk; LD_RELOAD = ld; START = st; STOP = sp; MODE_WR = mw; ACK = ak;
    DIN = d[W-1:0];
    if (mw) m_mode = d[0];
    te = tk;
`ifdef SYNC_TIMER_PRESCALE_EN
    te = 1'b0;
    if (sp || st) m_pre = 0;
    else if (m_run && tk) begin
      if (m_pre == ps) begin m_pre = 0; te = 1'b1; end
      else m_pre++;
    end
`endif
    term = 1'b0;
    if (sp) m_run = 1'b0;
    else if (st) begin
      m_cnt = ld ? d : m_rel;
      m_run = 1'b1;
    end else if (m_run && te) begin
      if (m_cnt == 0) begin
        term = 1'b1;
        if (m_mode) m_cnt = m_rel;
        else        m_run = 1'b0;
      end else m_cnt--;
    end
    if (ld) m_rel = d;
    m_tc  = term;
    m_irq = term || (m_irq && !ak);
    sb.push_back('{m_cnt, m_tc, m_irq, m_run});
    @(posedge MasterClock); #1;
    e = sb.pop_front();
    chk("sb_count", int'(COUNT), e.cnt);
    chk("sb_tc", int'(TC), int'(e.tc));
    chk("sb_irq", int'(IRQ), int'(e.irq));
    chk("sb_run", int'(RUNNING), int'(e.run));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int pseq[8];
    int ntc;
    pseq = '{2, 1, 0, 3, 2, 1, 0, 3};
    RESET = 1'b1; TICK = 0; LD_RELOAD = 0; START = 0; STOP = 0;
    MODE_WR = 0; ACK = 0; DIN = '0;
`ifdef SYNC_TIMER_PRESCALE_EN
    PRESCALE = 8'd0; ps = 0;
`endif
    model_reset();
    #12;
    chk("rst_count", int'(COUNT), 0);
    chk("rst_tc", int'(TC), 0);
    chk("rst_irq", int'(IRQ), 0);
    chk("rst_run", int'(RUNNING), 0);
    @(negedge MasterClock); RESET = 1'b0;
    @(posedge MasterClock); #1;

    // periodic, reload 3
    step(0, 1, 0, 0, 0, 0, 3);
    step(0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("p_start", int'(COUNT), 3);
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      chk("p_count", int'(COUNT), pseq[i]);
      chk("p_tc", int'(TC), int'(i % 4 == 3));
    end
    chk("p_irq", int'(IRQ), 1);

    // ack coincident with TC set, then ack alone
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 1, 0);
    chk("ack_set_tc", int'(TC), 1);
    chk("ack_set_irq", int'(IRQ), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ack_clr", int'(IRQ), 0);

    // one-shot, reload 2
    step(0, 0, 0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0, 2);
    step(0, 0, 1, 0, 0, 0, 0);
    ntc = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      ntc += int'(TC);
    end
    chk("os_tcs", ntc, 1);
    chk("os_run", int'(RUNNING), 0);
    chk("os_count", int'(COUNT), 0);

    // START+STOP together, then START with LD_RELOAD bypass
    step(0, 1, 0, 0, 0, 0, 5);
    step(0, 0, 1, 1, 0, 0, 0);
    chk("ss_run", int'(RUNNING), 0);
    chk("ss_count", int'(COUNT), 0);
    step(0, 1, 1, 0, 0, 0, 9);
    chk("byp_count", int'(COUNT), 9);
    chk("byp_run", int'(RUNNING), 1);

    // reload 0, periodic, alternating tick
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(i % 2 == 0, 0, 0, 0, 0, 0, 0);
      chk("z_tc", int'(TC), int'(i % 2 == 0));
      chk("z_count", int'(COUNT), 0);
    end

    // asynchronous reset mid-count
    step(0, 1, 0, 0, 0, 0, 10);
    step(0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("pre_rst", int'(COUNT), 7);
    #2 RESET = 1'b1;
    #1;
    chk("arst_count", int'(COUNT), 0);
    chk("arst_tc", int'(TC), 0);
    chk("arst_irq", int'(IRQ), 0);
    chk("arst_run", int'(RUNNING), 0);
    model_reset();
    @(negedge MasterClock); RESET = 1'b0;
    @(posedge MasterClock); #1;
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0);
    chk("post_rst_run", int'(RUNNING), 0);

    // random traffic against the model
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
           int'($urandom_range(0, 6)));

`ifdef SYNC_TIMER_PRESCALE_EN
    // prescale 2, reload 1: TC every 6 ticks
    ps = 2; PRESCALE = 8'd2;
    step(0, 0, 0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 0, 0);
    ntc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1, 0, 0, 0, 0, 0, 0);
      ntc += int'(TC);
      chk("ps_tc", int'(TC), int'(i % 6 == 5));
    end
    chk("ps_tcs", ntc, 2);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
